free_list: RTL and testbench

FREE_LIST -- requirements
Module: free_list

---
 rtl/free_list_if.sv | 55 +++++
 rtl/free_list.sv | 184 ++++++++++++++++++
 tb/tb_free_list.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/free_list_if.sv
// -----------------------------------------------------------------------------
// free_list_if
// Bundles the allocation, release, checkpoint and status signals of the
// physical-register free list. The clock and reset stay plain module ports.
//
//   pop_en_1/2, pop_data_1/2        : allocation request / allocated tags
//   alloc_ready_1/2                 : at least one / two entries free
//   push_en_1/2, push_data_1/2      : tags released at commit
//   take_checkpoint, dual_branch,
//   instr_num, current_id           : branch checkpoint control / next slot
//   restore_en, restore_id          : misprediction restore
//   free_count, err_flag            : occupancy and sticky error
//
// slave  : the free list itself
// master : the rename / commit logic driving it
// -----------------------------------------------------------------------------
interface free_list_if #(
   parameter int P_ADDR_WIDTH = 7,
   parameter int C_NUM        = 2
);
   localparam int CW = $clog2(C_NUM);

   logic                    pop_en_1;
   logic                    pop_en_2;
   logic [P_ADDR_WIDTH-1:0] pop_data_1;
   logic [P_ADDR_WIDTH-1:0] pop_data_2;
   logic                    alloc_ready_1;
   logic                    alloc_ready_2;
   logic                    push_en_1;
   logic                    push_en_2;
   logic [P_ADDR_WIDTH-1:0] push_data_1;
   logic [P_ADDR_WIDTH-1:0] push_data_2;
   logic                    take_checkpoint;
   logic                    dual_branch;
   logic                    instr_num;
   logic [CW-1:0]           current_id;
   logic                    restore_en;
   logic [CW-1:0]           restore_id;
   logic [P_ADDR_WIDTH:0]   free_count;
   logic                    err_flag;

   modport slave (
      input  pop_en_1, pop_en_2, push_en_1, push_en_2, push_data_1, push_data_2,
             take_checkpoint, dual_branch, instr_num, restore_en, restore_id,
      output pop_data_1, pop_data_2, alloc_ready_1, alloc_ready_2,
             current_id, free_count, err_flag
   );

   modport master (
      output pop_en_1, pop_en_2, push_en_1, push_en_2, push_data_1, push_data_2,
             take_checkpoint, dual_branch, instr_num, restore_en, restore_id,
      input  pop_data_1, pop_data_2, alloc_ready_1, alloc_ready_2,
             current_id, free_count, err_flag
   );
endinterface

// File: rtl/free_list.sv
// -----------------------------------------------------------------------------
// free_list
// Circular free list of physical register tags with branch checkpoints.
// Up to two tags are allocated and two released per cycle. Head/tail carry one
// extra wrap bit so that full (P_REGS) and empty (0) are distinguishable and
// free_count is simply tail - head.
//
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   fl     : free_list_if.slave (allocation, release, checkpoint, status)
//
// Optional feature: define FREE_LIST_ERR_CHK_EN to make err_flag a sticky
// underflow/overflow indicator; otherwise err_flag is tied low. Pointer
// protection against underflow/overflow is always active.
// -----------------------------------------------------------------------------
module free_list #(
   parameter int P_ADDR_WIDTH = 7,
   parameter int L_REGS       = 32,
   parameter int C_NUM        = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   free_list_if.slave fl
);
   localparam int P_REGS      = 2 ** P_ADDR_WIDTH;
   localparam int PW          = P_ADDR_WIDTH + 1;
   localparam int CW          = $clog2(C_NUM);
   // Number of free tags above the mapped range; these fill index 0 upward.
   localparam int RESET_SPLIT = P_REGS - L_REGS - 8;
   localparam logic [PW:0]   LP_CAP     = {1'b0, 1'b1, {P_ADDR_WIDTH{1'b0}}};
   localparam logic [PW-1:0] LP_PTR_ONE = PW'(1'b1);
   localparam logic [PW-1:0] LP_PTR_TWO = PW'(2'd2);

   // Reset content: free tags L_REGS+8..P_REGS-1, then 0..7.
   function automatic logic [P_ADDR_WIDTH-1:0] f_reset_tag(input int idx);
      int v;
      if (idx < RESET_SPLIT) begin
         v = L_REGS + 8 + idx;
      end else begin
         v = idx - RESET_SPLIT;
      end
      return v[P_ADDR_WIDTH-1:0];
   endfunction

   logic [P_ADDR_WIDTH-1:0] r_mem [P_REGS];
   logic [PW-1:0]           r_head;
   logic [PW-1:0]           r_tail;
   logic [PW-1:0]           r_ckp_head [C_NUM];
   logic [CW-1:0]           r_current_id;

   logic [PW-1:0]           w_count;
   logic [1:0]              w_pop_num;
   logic [1:0]              w_push_num;
   logic                    w_pop_ok;
   logic                    w_push_ok;
   logic [PW:0]             w_push_total;
   logic [P_ADDR_WIDTH-1:0] w_head_idx;
   logic [P_ADDR_WIDTH-1:0] w_head_p1_idx;
   logic [P_ADDR_WIDTH-1:0] w_tail_idx;
   logic [P_ADDR_WIDTH-1:0] w_tail_2_idx;
   logic [CW-1:0]           w_cid_p1;
   logic [PW-1:0]           w_head_nxt;
   logic [PW-1:0]           w_tail_nxt;
   logic [PW-1:0]           w_ckp_nxt [C_NUM];
   logic [CW-1:0]           w_cid_nxt;

   assign w_count       = r_tail - r_head;
   assign w_pop_num     = {1'b0, fl.pop_en_1} + {1'b0, fl.pop_en_2};
   assign w_push_num    = {1'b0, fl.push_en_1} + {1'b0, fl.push_en_2};
   // A pop group commits only if every requested tag is available.
   assign w_pop_ok      = (w_count >= PW'(w_pop_num));
   // Capacity check uses the pre-cycle count so a push never lands on a slot
   // that is still being read this cycle.
   assign w_push_total  = {1'b0, w_count} + (PW + 1)'(w_push_num);
   assign w_push_ok     = (w_push_total <= LP_CAP);
   assign w_head_idx    = r_head[P_ADDR_WIDTH-1:0];
   assign w_head_p1_idx = w_head_idx + P_ADDR_WIDTH'(1'b1);
   assign w_tail_idx    = r_tail[P_ADDR_WIDTH-1:0];
   assign w_tail_2_idx  = w_tail_idx + P_ADDR_WIDTH'(fl.push_en_1);
   assign w_cid_p1      = r_current_id + CW'(1'b1);

   assign fl.pop_data_1    = r_mem[w_head_idx];
   assign fl.pop_data_2    = fl.pop_en_1 ? r_mem[w_head_p1_idx] : r_mem[w_head_idx];
   assign fl.alloc_ready_1 = (w_count >= LP_PTR_ONE);
   assign fl.alloc_ready_2 = (w_count >= LP_PTR_TWO);
   assign fl.free_count    = w_count;
   assign fl.current_id    = r_current_id;

   // Next head, tail, checkpoint slots and slot counter.
   always_comb begin
      w_head_nxt = r_head;
      w_tail_nxt = r_tail;
      w_ckp_nxt  = r_ckp_head;
      w_cid_nxt  = r_current_id;
      if (fl.restore_en) begin
         // Restore wins over same-cycle pops and checkpoints.
         w_head_nxt = r_ckp_head[fl.restore_id];
      end else begin
         if (w_pop_ok) begin
            w_head_nxt = r_head + PW'(w_pop_num);
         end else begin
            w_head_nxt = r_head;
         end
         if (fl.take_checkpoint) begin
            if (fl.dual_branch) begin
               w_ckp_nxt[r_current_id] = r_head + PW'(fl.pop_en_1);
               w_ckp_nxt[w_cid_p1]     = r_head + PW'(w_pop_num);
               w_cid_nxt               = r_current_id + CW'(2'd2);
            end else begin
               // instr_num selects whether the branch sits after slot 2.
               w_ckp_nxt[r_current_id] = r_head + PW'(fl.pop_en_1)
                                       + PW'(fl.instr_num & fl.pop_en_2);
               w_cid_nxt               = w_cid_p1;
            end
         end else begin
            w_cid_nxt = r_current_id;
         end
      end
      if (w_push_ok) begin
         w_tail_nxt = r_tail + PW'(w_push_num);
      end else begin
         w_tail_nxt = r_tail;
      end
   end

   // Pointer, checkpoint and slot-counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head       <= {PW{1'b0}};
         r_tail       <= PW'(P_REGS - L_REGS);
         r_current_id <= {CW{1'b0}};
         for (int i = 0; i < C_NUM; i++) begin
            r_ckp_head[i] <= {PW{1'b0}};
         end
      end else begin
         r_head       <= w_head_nxt;
         r_tail       <= w_tail_nxt;
         r_current_id <= w_cid_nxt;
         for (int i = 0; i < C_NUM; i++) begin
            r_ckp_head[i] <= w_ckp_nxt[i];
         end
      end
   end

   // Tag storage: reset image, then released tags written at the tail.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < P_REGS; i++) begin
            r_mem[i] <= f_reset_tag(i);
         end
      end else if (w_push_ok) begin
         if (fl.push_en_1) begin
            r_mem[w_tail_idx] <= fl.push_data_1;
         end
         if (fl.push_en_2) begin
            r_mem[w_tail_2_idx] <= fl.push_data_2;
         end
      end
   end

`ifdef FREE_LIST_ERR_CHK_EN
   logic r_err_flag;
   logic w_underflow;
   logic w_overflow;

   assign w_underflow = ~fl.restore_en & ~w_pop_ok;
   assign w_overflow  = ~w_push_ok;

   // Sticky error, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_flag <= 1'b0;
      end else if (w_underflow | w_overflow) begin
         r_err_flag <= 1'b1;
      end
   end

   assign fl.err_flag = r_err_flag;
`else
   assign fl.err_flag = 1'b0;
`endif

endmodule

// File: tb/tb_free_list.sv
module tb_free_list;
   localparam int AW  = 7;
   localparam int LR  = 32;
   localparam int CN  = 2;
   localparam int PR  = 128;
   localparam int CWB = $clog2(CN);
`ifdef FREE_LIST_ERR_CHK_EN
   localparam bit ERR_ON = 1'b1;
`else
   localparam bit ERR_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   free_list_if #(.P_ADDR_WIDTH(AW), .C_NUM(CN)) fl ();

   free_list #(.P_ADDR_WIDTH(AW), .L_REGS(LR), .C_NUM(CN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .fl    (fl)
   );

   typedef struct {
      bit p1; bit p2; bit u1; bit u2; int d1; int d2;
      bit tk; bit du; bit in; bit rs; int rid;
      int e_pd1; int e_pd2; int e_cnt; int e_cur;
   } vec_t;

   typedef struct {
      int    cnt;
      bit    r1;
      bit    r2;
      int    cur;
      bit    err;
      string tag;
   } exp_t;

   exp_t sbq[$];
   int   checks   = 0;
   int   failures = 0;

   // reference model: tags kept by absolute sequence number, no wrap
   int hist[$];
   int hseq, tseq, mcur;
   int mckp[CN];
   bit merr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic drive(input bit p1, p2, u1, u2, input int d1, d2,
                        input bit tk, du, in, rs, input int rid);
      fl.pop_en_1        = p1;
      fl.pop_en_2        = p2;
      fl.push_en_1       = u1;
      fl.push_en_2       = u2;
      fl.push_data_1     = d1[AW-1:0];
      fl.push_data_2     = d2[AW-1:0];
      fl.take_checkpoint = tk;
      fl.dual_branch     = du;
      fl.instr_num       = in;
      fl.restore_en      = rs;
      fl.restore_id      = rid[CWB-1:0];
   endtask

   task automatic model_reset();
      hist.delete();
      for (int t = LR + 8; t < PR; t++) hist.push_back(t);
      for (int t = 0; t < 8; t++) hist.push_back(t);
      hseq = 0;
      tseq = PR - LR;
      mcur = 0;
      merr = 1'b0;
      for (int i = 0; i < CN; i++) mckp[i] = 0;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic check_post();
      exp_t e;
      if (sbq.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_empty actual=0 required=1");
      end else begin
         e = sbq.pop_front();
         chk({e.tag, " free_count"},    fl.free_count,    e.cnt);
         chk({e.tag, " alloc_ready_1"}, fl.alloc_ready_1, e.r1);
         chk({e.tag, " alloc_ready_2"}, fl.alloc_ready_2, e.r2);
         chk({e.tag, " current_id"},    fl.current_id,    e.cur);
         chk({e.tag, " err_flag"},      fl.err_flag,      e.err);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      exp_t e;
      @(negedge clk);
      drive(v.p1, v.p2, v.u1, v.u2, v.d1, v.d2, v.tk, v.du, v.in, v.rs, v.rid);
      e.cnt = v.e_cnt; e.r1 = (v.e_cnt >= 1); e.r2 = (v.e_cnt >= 2);
      e.cur = v.e_cur; e.err = 1'b0; e.tag = $sformatf("vec%0d", idx);
      sbq.push_back(e);
      #1;
      chk($sformatf("vec%0d pop_data_1", idx), fl.pop_data_1, v.e_pd1);
      chk($sformatf("vec%0d pop_data_2", idx), fl.pop_data_2, v.e_pd2);
      @(posedge clk);
      #1;
      check_post();
   endtask

   // one model-checked cycle
   task automatic mstep(input string tag, input bit p1, p2, u1, u2, input int d1, d2,
                        input bit tk, du, in, rs, input int rid);
      exp_t e;
      int   cnt, np, nu, epd1, epd2;
      bit   c1, c2;
      @(negedge clk);
      drive(p1, p2, u1, u2, d1, d2, tk, du, in, rs, rid);
      cnt  = tseq - hseq;
      np   = int'(p1) + int'(p2);
      nu   = int'(u1) + int'(u2);
      c1   = (cnt >= 1);
      c2   = (cnt >= (p1 ? 2 : 1));
      epd1 = c1 ? hist[hseq] : 0;
      epd2 = c2 ? (p1 ? hist[hseq + 1] : hist[hseq]) : 0;
      if (!rs && tk) begin
         if (du) begin
            mckp[mcur]            = hseq + int'(p1);
            mckp[(mcur + 1) % CN] = hseq + np;
            mcur                  = (mcur + 2) % CN;
         end else begin
            mckp[mcur] = hseq + int'(p1) + int'(in & p2);
            mcur       = (mcur + 1) % CN;
         end
      end
      if (rs) hseq = mckp[rid];
      else if (cnt >= np) hseq = hseq + np;
      else merr = 1'b1;
      if (cnt + nu <= PR) begin
         if (u1) hist.push_back(d1);
         if (u2) hist.push_back(d2);
         tseq = tseq + nu;
      end else begin
         merr = 1'b1;
      end
      e.cnt = tseq - hseq; e.r1 = (e.cnt >= 1); e.r2 = (e.cnt >= 2);
      e.cur = mcur; e.err = merr & ERR_ON; e.tag = tag;
      sbq.push_back(e);
      #1;
      if (c1) chk({tag, " pop_data_1"}, fl.pop_data_1, epd1);
      if (c2) chk({tag, " pop_data_2"}, fl.pop_data_2, epd2);
      @(posedge clk);
      #1;
      check_post();
   endtask

   vec_t vt[13];

   initial begin
      //          p1 p2 u1 u2 d1 d2 tk du in rs rid pd1 pd2 cnt cur
      vt[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 40, 41, 94, 0};
      vt[1]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 42, 43, 93, 0};
      vt[2]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 43, 43, 92, 0};
      vt[3]  = '{0, 0, 1, 0, 40, 0, 0, 0, 0, 0, 0, 44, 44, 93, 0};
      vt[4]  = '{1, 1, 1, 1, 41, 42, 0, 0, 0, 0, 0, 44, 45, 93, 0};
      vt[5]  = '{1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 46, 47, 91, 0};
      vt[6]  = '{1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 48, 49, 89, 1};
      vt[7]  = '{1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 50, 51, 87, 0};
      vt[8]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 52, 53, 85, 0};
      vt[9]  = '{1, 1, 1, 0, 45, 0, 0, 0, 0, 1, 0, 54, 55, 91, 0};
      vt[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 49, 49, 91, 0};
      vt[11] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 49, 49, 88, 0};
      vt[12] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 52, 53, 87, 0};

      do_reset();
      #1;
      chk("reset free_count",    fl.free_count,    96);
      chk("reset alloc_ready_1", fl.alloc_ready_1, 1);
      chk("reset alloc_ready_2", fl.alloc_ready_2, 1);
      chk("reset pop_data_1",    fl.pop_data_1,    40);
      chk("reset current_id",    fl.current_id,    0);
      chk("reset err_flag",      fl.err_flag,      0);

      for (int i = 0; i < 13; i++) run_vec(vt[i], i);

      // dual checkpoint at head 0, four more pops, restore slot 1 -> head 2
      do_reset();
      mstep("ckp_dual", 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      mstep("pop_a",    1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      mstep("pop_b",    1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      mstep("restore1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      chk("restore1 free_count", fl.free_count, 94);
      chk("restore1 pop_data_1", fl.pop_data_1, 42);

      // drain to one entry, then underflow attempts
      do_reset();
      for (int i = 0; i < 47; i++) mstep("drain", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      mstep("drain_last", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      mstep("under_2",    1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("under_2 free_count", fl.free_count, 1);
      mstep("pop_to_0",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      mstep("under_1",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // empty, refill to full across index 127, overflow, drain in FIFO order
      do_reset();
      for (int i = 0; i < 48; i++) mstep("empty", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 64; i++)
         mstep("fill", 0, 0, 1, 1, (i * 74 + 5) % PR, (i * 74 + 42) % PR, 0, 0, 0, 0, 0);
      chk("full free_count", fl.free_count, 128);
      mstep("overflow", 0, 0, 1, 0, 9, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 64; i++) mstep("fifo", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++)
         mstep("wrap_push", 0, 0, 1, 1, (i * 3 + 1) % PR, (i * 5 + 2) % PR, 0, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) mstep("wrap_pop", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // reset in the middle of pending pops and pushes
      @(negedge clk);
      drive(1, 1, 1, 0, 77, 0, 1, 1, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midreset free_count", fl.free_count, 96);
      chk("midreset pop_data_1", fl.pop_data_1, 40);
      chk("midreset current_id", fl.current_id, 0);
      @(posedge clk);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("after_reset free_count", fl.free_count, 96);

      if (sbq.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_leftover actual=%0d required=0", sbq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
